// File: rtl/rsa_arith_pkg.sv
// Shared types and constants for the RSA arithmetic datapath (divider and multiplier).
// The state encoding is common so both units can be traced with the same decoder.
package rsa_arith_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The counter must hold the value WIDTH itself, which marks the end of the shift phase.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/multiplier32_seq.sv
// Sequential shift-and-add multiply-accumulate: product = quot*divisor + rem_in.
// Also flags operands that cannot come from a legal division (rem_in >= divisor).
module multiplier32_seq
  import rsa_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quot,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     rem_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 err
);

  localparam int CNT_W = (WIDTH == DEFAULT_WIDTH) ? DEFAULT_CNT_W : cntWidth(WIDTH);

  state_e               r_state;
  state_e               w_nextState;
  logic [WIDTH-1:0]     r_accHi;
  logic [WIDTH-1:0]     r_accLo;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_addend;
  logic [CNT_W-1:0]     r_count;
  logic                 r_errPend;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_lastIter;
  logic [WIDTH:0]       w_partial;
  logic [2*WIDTH-1:0]   w_final;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastIter = (r_count == CNT_W'(WIDTH));

  // The carry out of the high half is kept so the right shift brings it back in.
  assign w_partial  = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_final    = {r_accHi, r_accLo} + {{WIDTH{1'b0}}, r_addend};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastIter) w_nextState = ADD;
      end
      ADD: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = start ? RUN : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The previous result stays visible while a new job runs; it only changes on the ADD edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_mcand   <= '0;
      r_addend  <= '0;
      r_count   <= '0;
      r_errPend <= 1'b0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_accHi   <= '0;
      r_accLo   <= quot;
      r_mcand   <= divisor;
      r_addend  <= rem_in;
      r_count   <= '0;
      r_errPend <= (rem_in >= divisor);
    end else begin
      case (r_state)
        RUN: begin
          if (!w_lastIter) begin
            r_accHi <= w_partial[WIDTH:1];
            r_accLo <= {w_partial[0], r_accLo[WIDTH-1:1]};
            r_count <= r_count + CNT_W'(1);
          end
        end
        ADD: begin
          {r_accHi, r_accLo} <= w_final;
          r_product          <= w_final;
          r_err              <= r_errPend;
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;
  assign err     = r_err;

endmodule

// File: tb/tb_multiplier32_seq.sv
// Scoreboard bench for multiplier32_seq: stimulus pushes expected results from a plain
// arithmetic model, a negedge monitor checks busy every cycle and pops on each done.
module tb_multiplier32_seq;

  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           err;
    int             doneEdge;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     quot;
  logic [W-1:0]     divisor;
  logic [W-1:0]     rem_in;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic             err;

  exp_t expQ[$];
  int   edgeCount = 0;
  int   curAccept = -1;
  int   checks    = 0;
  int   failures  = 0;

  multiplier32_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .quot    (quot),
    .divisor (divisor),
    .rem_in  (rem_in),
    .busy    (busy),
    .done    (done),
    .product (product),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: full-width integer arithmetic; result appears W+2 edges after acceptance.
  function automatic exp_t refModel(input logic [W-1:0] q, input logic [W-1:0] b,
                                    input logic [W-1:0] r, input int acceptEdge);
    exp_t e;
    logic [2*W-1:0] qw;
    logic [2*W-1:0] bw;
    logic [2*W-1:0] rw;
    qw = {{W{1'b0}}, q};
    bw = {{W{1'b0}}, b};
    rw = {{W{1'b0}}, r};
    e.prod     = qw * bw + rw;
    e.err      = (r >= b);
    e.doneEdge = acceptEdge + W + 2;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeCount, actual, required);
    end
  endtask

  // Called just after a rising edge; the job is accepted on the following edge.
  task automatic applyStimulus(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r);
    quot    = q;
    divisor = b;
    rem_in  = r;
    start   = 1'b1;
    @(posedge clk);
    #1;
    curAccept = edgeCount;
    expQ.push_back(refModel(q, b, r, edgeCount));
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int i;
    i = 0;
    while (expQ.size() > 0 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (expQ.size() > 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic busyExp;
      logic doneExp;
      exp_t e;
      busyExp = (curAccept >= 0) && (edgeCount >= curAccept) && (edgeCount <= curAccept + W + 1);
      doneExp = (expQ.size() > 0) && (expQ[0].doneEdge == edgeCount);
      checkOutput("busy", 64'(busy), 64'(busyExp));
      checkOutput("done", 64'(done), 64'(doneExp));
      if (doneExp) begin
        e = expQ.pop_front();
        if (done) begin
          checkOutput("product", product, e.prod);
          checkOutput("err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] q;
    logic [W-1:0] b;
    logic [W-1:0] r;
    int           firstDone;

    rst     = 1'b1;
    start   = 1'b0;
    quot    = '0;
    divisor = '0;
    rem_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", product, 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic job 10*7+3");
    applyStimulus(32'h0000000A, 32'h00000007, 32'h00000003);
    waitIdle();
    checkOutput("hold_product", product, 64'h0000000000000049);

    $display("[TB] all-ones operands");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle();

    $display("[TB] zero divisor");
    applyStimulus(32'h12345678, 32'h00000000, 32'h00000009);
    waitIdle();

    $display("[TB] start during busy is ignored");
    applyStimulus(32'h00001234, 32'h00000567, 32'h00000011);
    repeat (9) @(posedge clk);
    #1;
    quot    = 32'hDEADBEEF;
    divisor = 32'h00000001;
    rem_in  = 32'h00000005;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_after_ignore", product, 64'h0000000000000000 + 64'h1234 * 64'h567 + 64'h11);

    $display("[TB] reset in the middle of a job");
    applyStimulus(32'h00ABCDEF, 32'h00000100, 32'h00000200);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_product", product, 64'd0);
    checkOutput("midrst_err", 64'(err), 64'd0);
    expQ.delete();
    curAccept = -1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h00000021, 32'h00000004, 32'h00000002);
    waitIdle();

    $display("[TB] back-to-back with start held through DONE");
    applyStimulus(32'h0000BEEF, 32'h00000ACE, 32'h00000003);
    firstDone = curAccept + W + 2;
    repeat (20) @(posedge clk);
    #1;
    quot    = 32'd3;
    divisor = 32'd5;
    rem_in  = 32'd4;
    start   = 1'b1;
    while (edgeCount < firstDone) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(32'd3, 32'd5, 32'd4);
    checkOutput("b2b_spacing", 64'(expQ[expQ.size()-1].doneEdge - firstDone), 64'd35);
    waitIdle();
    checkOutput("b2b_product", product, 64'h13);

    $display("[TB] randomized jobs");
    for (int i = 0; i < 10; i++) begin
      q = $urandom;
      b = (i % 4 == 0) ? W'($urandom_range(0, 3)) : $urandom;
      if (i % 2 == 0 && b != 0) r = $urandom % b;
      else r = $urandom;
      if (i == 5) q = '0;
      applyStimulus(q, b, r);
      waitIdle();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
